// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client arbiter that shares one word-granular memory port
// between the instruction cache (client 0) and the data cache (client 1).
//
// Each client has a one-entry request slot. Slots are granted one at a time
// to memory, and the response is steered back to the client that owns the
// transaction. After each completed transaction, the last-served client
// holds a short ownership lock so that a 4-word line fill stays contiguous.
//
// Ports
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_cN_addr/ren/wen/wdata         client N request (N = 0 icache, 1 dcache)
//   o_cN_ready                      client N slot empty
//   o_cN_rdata/o_cN_valid           client N response (rdata mirrors memory)
//   i_mem_ready                     memory can accept a request
//   o_mem_addr/ren/wen/wdata        registered one-cycle memory request
//   i_mem_rdata/i_mem_valid         memory response (reads and write acks)
//
// Parameter
//   LOCK_CYCLES (0..3)  idle cycles after a response in which only the
//                       last-served client may be granted
module mem_arbiter #(
    parameter int unsigned LOCK_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_c0_addr,
    input  logic        i_c0_ren,
    input  logic        i_c0_wen,
    input  logic [31:0] i_c0_wdata,
    output logic        o_c0_ready,
    output logic [31:0] o_c0_rdata,
    output logic        o_c0_valid,
    input  logic [31:0] i_c1_addr,
    input  logic        i_c1_ren,
    input  logic        i_c1_wen,
    input  logic [31:0] i_c1_wdata,
    output logic        o_c1_ready,
    output logic [31:0] o_c1_rdata,
    output logic        o_c1_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    localparam logic [1:0] LOCK_INIT = 2'(LOCK_CYCLES);

    // Request slots
    logic        s0_full_q, s1_full_q;
    logic [31:0] s0_addr_q, s1_addr_q;
    logic [31:0] s0_wdata_q, s1_wdata_q;
    logic        s0_we_q, s1_we_q;

    // Arbitration / FSM state
    state_e      state_q;
    logic        owner_q;
    logic        last_q;
    logic [1:0]  lock_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        mem_ren_q, mem_wen_q;

    // Grant decision for this cycle
    logic gnt_vld, gnt_id;
    logic gnt0, gnt1;
    logic cap0, cap1;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state_q == S_IDLE && i_mem_ready) begin
            if (lock_q != 2'd0) begin
                // Locked: only the last-served client may go.
                if (last_q ? s1_full_q : s0_full_q) begin
                    gnt_vld = 1'b1;
                    gnt_id  = last_q;
                end
            end else if (s0_full_q && s1_full_q) begin
                // Tie: round-robin away from the last-served client.
                gnt_vld = 1'b1;
                gnt_id  = ~last_q;
            end else if (s0_full_q) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (s1_full_q) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign gnt0 = gnt_vld && !gnt_id;
    assign gnt1 = gnt_vld &&  gnt_id;

    // A slot being granted this edge is free to capture a new request.
    // The grant uses the old contents.
    assign cap0 = (i_c0_ren || i_c0_wen) && (!s0_full_q || gnt0);
    assign cap1 = (i_c1_ren || i_c1_wen) && (!s1_full_q || gnt1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_full_q  <= 1'b0;
            s0_addr_q  <= '0;
            s0_wdata_q <= '0;
            s0_we_q    <= 1'b0;
            s1_full_q  <= 1'b0;
            s1_addr_q  <= '0;
            s1_wdata_q <= '0;
            s1_we_q    <= 1'b0;
        end else begin
            if (cap0) begin
                s0_full_q  <= 1'b1;
                s0_addr_q  <= i_c0_addr;
                s0_wdata_q <= i_c0_wdata;
                s0_we_q    <= i_c0_wen;   // ren&wen together counts as a write
            end else if (gnt0) begin
                s0_full_q  <= 1'b0;
            end
            if (cap1) begin
                s1_full_q  <= 1'b1;
                s1_addr_q  <= i_c1_addr;
                s1_wdata_q <= i_c1_wdata;
                s1_we_q    <= i_c1_wen;
            end else if (gnt1) begin
                s1_full_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            lock_q      <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
        end else begin
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        mem_addr_q  <= gnt_id ? s1_addr_q  : s0_addr_q;
                        mem_wdata_q <= gnt_id ? s1_wdata_q : s0_wdata_q;
                        mem_ren_q   <= gnt_id ? !s1_we_q   : !s0_we_q;
                        mem_wen_q   <= gnt_id ? s1_we_q    : s0_we_q;
                        owner_q     <= gnt_id;
                        // Any grant while locked is to last_served; an
                        // unlocked grant leaves lock at zero anyway.
                        lock_q      <= 2'd0;
                        state_q     <= S_WAIT;
                    end else if (i_mem_ready && lock_q != 2'd0) begin
                        // Lock only counts down while memory could take work.
                        lock_q <= lock_q - 2'd1;
                    end
                end
                S_WAIT: begin
                    if (i_mem_valid) begin
                        last_q  <= owner_q;
                        lock_q  <= LOCK_INIT;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_c0_ready  = !s0_full_q;
    assign o_c1_ready  = !s1_full_q;
    assign o_c0_rdata  = i_mem_rdata;
    assign o_c1_rdata  = i_mem_rdata;
    // A response is only meaningful while a transaction is outstanding.
    assign o_c0_valid  = (state_q == S_WAIT) && i_mem_valid && !owner_q;
    assign o_c1_valid  = (state_q == S_WAIT) && i_mem_valid &&  owner_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_ren   = mem_ren_q;
    assign o_mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LOCK_CYCLES=2 instance driven step by
// step, plus a LOCK_CYCLES=0 instance whose clients re-request continuously.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Main instance (LOCK_CYCLES = 2)
    logic [31:0] c0_addr, c1_addr, c0_wdata, c1_wdata;
    logic        c0_ren, c0_wen, c1_ren, c1_wen;
    logic        c0_ready, c1_ready, c0_valid, c1_valid;
    logic [31:0] c0_rdata, c1_rdata;
    logic        mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen, mem_valid;

    // Memory responder: valid two cycles after each request pulse
    logic        resp_valid = 1'b0;
    logic        force_valid;
    logic        resp_en;
    logic [31:0] resp_data;
    int          resp_cnt = 0;

    assign mem_valid = resp_valid | force_valid;
    assign mem_rdata = resp_data;

    mem_arbiter #(.LOCK_CYCLES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_c0_addr(c0_addr), .i_c0_ren(c0_ren), .i_c0_wen(c0_wen), .i_c0_wdata(c0_wdata),
        .o_c0_ready(c0_ready), .o_c0_rdata(c0_rdata), .o_c0_valid(c0_valid),
        .i_c1_addr(c1_addr), .i_c1_ren(c1_ren), .i_c1_wen(c1_wen), .i_c1_wdata(c1_wdata),
        .o_c1_ready(c1_ready), .o_c1_rdata(c1_rdata), .o_c1_valid(c1_valid),
        .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren),
        .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid)
    );

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            resp_cnt   = 0;
            resp_valid = 1'b0;
        end else begin
            resp_valid = (resp_cnt == 1);
            if (resp_cnt > 0) resp_cnt = resp_cnt - 1;
            if (resp_en && (mem_ren || mem_wen)) resp_cnt = 2;
        end
    end

    logic [31:0] log_a[$];
    always @(negedge clk) if (mem_ren || mem_wen) log_a.push_back(mem_addr);

    // Second instance (LOCK_CYCLES = 0), clients always re-requesting
    logic        run_b;
    logic        b_c0_ready, b_c1_ready, b_c0_valid, b_c1_valid;
    logic        b_c0_ren, b_c1_ren;
    logic [31:0] b_c0_rdata, b_c1_rdata, b_mem_addr, b_mem_wdata;
    logic        b_mem_ren, b_mem_wen, b_mem_valid;

    assign b_c0_ren    = b_c0_ready & run_b;
    assign b_c1_ren    = b_c1_ready & run_b;
    assign b_mem_valid = b_mem_ren | b_mem_wen;

    mem_arbiter #(.LOCK_CYCLES(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_c0_addr(32'h0000_00A0), .i_c0_ren(b_c0_ren), .i_c0_wen(1'b0), .i_c0_wdata(32'h0),
        .o_c0_ready(b_c0_ready), .o_c0_rdata(b_c0_rdata), .o_c0_valid(b_c0_valid),
        .i_c1_addr(32'h0000_00B0), .i_c1_ren(b_c1_ren), .i_c1_wen(1'b0), .i_c1_wdata(32'h0),
        .o_c1_ready(b_c1_ready), .o_c1_rdata(b_c1_rdata), .o_c1_valid(b_c1_valid),
        .i_mem_ready(1'b1), .o_mem_addr(b_mem_addr), .o_mem_ren(b_mem_ren),
        .o_mem_wen(b_mem_wen), .o_mem_wdata(b_mem_wdata),
        .i_mem_rdata(32'h0), .i_mem_valid(b_mem_valid)
    );

    logic [31:0] log_b[$];
    always @(negedge clk) if (b_mem_ren) log_b.push_back(b_mem_addr);

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_c1v(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (c1_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [31:0] exp3 [5] = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h500};
    logic [31:0] expb [4] = '{32'hB0, 32'hA0, 32'hB0, 32'hA0};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int base, pulses;

        rst_n = 1'b0;
        c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
        c0_ren = 0; c0_wen = 0; c1_ren = 0; c1_wen = 0;
        mem_ready = 1'b1; force_valid = 1'b0; resp_en = 1'b1;
        resp_data = 32'hDEAD_BEEF; run_b = 1'b0;

        // Reset state
        step(); step();
        chk("rst_c0_ready", c0_ready, 1);
        chk("rst_c1_ready", c1_ready, 1);
        chk("rst_c0_valid", c0_valid, 0);
        chk("rst_c1_valid", c1_valid, 0);
        chk("rst_mem_ren",  mem_ren, 0);
        chk("rst_mem_wen",  mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        step();

        // Single c0 read at 0x100
        c0_addr = 32'h100; c0_ren = 1;
        step(); c0_ren = 0;
        chk("t1_slot_full", c0_ready, 0);
        chk("t1_no_early",  mem_ren, 0);
        step();
        chk("t1_ren",   mem_ren, 1);
        chk("t1_wen",   mem_wen, 0);
        chk("t1_addr",  mem_addr, 32'h100);
        chk("t1_slot_freed", c0_ready, 1);
        step();
        chk("t1_one_pulse", mem_ren, 0);
        chk("t1_no_valid_yet", c0_valid, 0);
        step();
        chk("t1_c0_valid", c0_valid, 1);
        chk("t1_c0_rdata", c0_rdata, 32'hDEAD_BEEF);
        chk("t1_c1_valid", c1_valid, 0);
        repeat (4) step();

        // Simultaneous first requests after reset: dcache wins
        rst_n = 0; step(); rst_n = 1; step();
        c0_addr = 32'h200; c0_ren = 1;
        c1_addr = 32'h300; c1_wen = 1; c1_wdata = 32'h1122_3344;
        step(); c0_ren = 0; c1_wen = 0;
        step();
        chk("t2_wen",   mem_wen, 1);
        chk("t2_ren",   mem_ren, 0);
        chk("t2_addr",  mem_addr, 32'h300);
        chk("t2_wdata", mem_wdata, 32'h1122_3344);
        step(); step();
        chk("t2_c1_valid", c1_valid, 1);
        chk("t2_c0_valid", c0_valid, 0);
        pulses = 0;
        repeat (3) begin
            step();
            if (mem_ren || mem_wen) pulses++;
        end
        chk("t2_lock_hold", pulses, 0);
        step();
        chk("t2_c0_ren",  mem_ren, 1);
        chk("t2_c0_addr", mem_addr, 32'h200);
        step(); step();
        chk("t2_c0_valid_late", c0_valid, 1);
        repeat (4) step();

        // c1 4-word fill with c0 competing
        base = log_a.size();
        c1_addr = 32'h400; c1_ren = 1;
        step(); c1_ren = 0;
        c0_addr = 32'h500; c0_ren = 1;
        step(); c0_ren = 0;
        for (int w = 1; w < 4; w++) begin
            wait_c1v(ok);
            chk("t3_fill_valid", ok, 1);
            step();
            c1_addr = 32'h400 + 32'(4 * w); c1_ren = 1;
            step(); c1_ren = 0;
        end
        for (int k = 0; k < 40 && log_a.size() < base + 5; k++) step();
        for (int i = 0; i < 5; i++)
            chk("t3_order", (base + i < log_a.size()) ? log_a[base + i] : 32'hFFFF_FFFF, exp3[i]);
        repeat (8) step();

        // LOCK_CYCLES = 0: strict alternation
        run_b = 1;
        for (int k = 0; k < 30 && log_b.size() < 4; k++) step();
        run_b = 0;
        for (int i = 0; i < 4; i++)
            chk("t4_alternate", (i < log_b.size()) ? log_b[i] : 32'hFFFF_FFFF, expb[i]);

        // Memory not ready for 5 cycles
        mem_ready = 0;
        c0_addr = 32'h600; c0_ren = 1;
        step(); c0_ren = 0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            if (mem_ren || mem_wen) pulses++;
            chk("t5_ready_low", c0_ready, 0);
        end
        chk("t5_no_pulse", pulses, 0);
        mem_ready = 1;
        step();
        chk("t5_ren",  mem_ren, 1);
        chk("t5_addr", mem_addr, 32'h600);
        repeat (6) step();

        // Reset while in WAIT, late response afterwards
        resp_en = 0;
        c1_addr = 32'h700; c1_ren = 1;
        step(); c1_ren = 0;
        step();
        chk("t6_ren",  mem_ren, 1);
        chk("t6_addr", mem_addr, 32'h700);
        step();
        rst_n = 0;
        #1;
        chk("t6_rst_addr",     mem_addr, 0);
        chk("t6_rst_c1_ready", c1_ready, 1);
        step();
        rst_n = 1;
        step();
        force_valid = 1;
        #1;
        chk("t6_late_c0_valid", c0_valid, 0);
        chk("t6_late_c1_valid", c1_valid, 0);
        chk("t6_c0_ready",      c0_ready, 1);
        chk("t6_c1_ready",      c1_ready, 1);
        chk("t6_mem_ren",       mem_ren, 0);
        chk("t6_mem_wen",       mem_wen, 0);
        chk("t6_mem_addr",      mem_addr, 0);
        chk("t6_mem_wdata",     mem_wdata, 0);
        step();
        force_valid = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client memory arbiter between the instruction cache and data cache, sharing one word-granular external memory port. It sits directly downstream of both cache instances. Each cache's memory-side interface connects to one client port. It buffers one request per client, serialises transactions to memory one at a time, and routes each response back to the requester. A short ownership lock keeps a cache's 4-word line fill contiguous.

## Interface
- `LOCK_CYCLES`, default 2: cycles after a completed transaction during which only the last-served client may be granted. Legal range 0..3.
- `i_clk`  in  1  global clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_c0_addr` / `i_c1_addr`  in  32  word address from client 0 (icache) / client 1 (dcache).
- `i_c0_ren` / `i_c1_ren`  in  1  read request pulse.
- `i_c0_wen` / `i_c1_wen`  in  1  write request pulse.
- `i_c0_wdata` / `i_c1_wdata`  in  32  write data.
- `o_c0_ready` / `o_c1_ready`  out  1  client request slot empty; request may be issued.
- `o_c0_rdata` / `o_c1_rdata`  out  32  read data, equal to `i_mem_rdata`.
- `o_c0_valid` / `o_c1_valid`  out  1  response (read data or write ack) for that client.
- `i_mem_ready`  in  1  memory can accept a request.
- `o_mem_addr`  out  32  request address.
- `o_mem_ren`, `o_mem_wen`  out  1  registered one-cycle request pulses.
- `o_mem_wdata`  out  32  write data.
- `i_mem_rdata`  in  32  read data.
- `i_mem_valid`  in  1  memory response, for both reads and writes.

## Operation
- Per-client slot holds {addr, wdata, is_write, full}.
  - At a clock edge where `ren|wen` is high and the slot is empty, the slot captures the request and full is set.
  - `o_cN_ready = !slotN.full`. It is combinational and independent of the other client and of memory state.
  - If `ren` and `wen` are both high, the request is captured as a write.
  - A request arriving while the slot is full is dropped. A well-behaved client never does this.
- FSM states: IDLE and WAIT.
- IDLE, while `i_mem_ready` is high and an eligible slot is full:
  - Grant that slot.
  - Register `o_mem_addr`, `o_mem_wdata`, and `o_mem_ren` or `o_mem_wen`, high for exactly one cycle.
  - Clear the slot, record owner = granted client, go to WAIT.
- WAIT, on `i_mem_valid`:
  - Assert `o_cOWNER_valid` combinationally in the same cycle. The other client's valid stays 0.
  - Set last_served = owner, load lock_cnt = LOCK_CYCLES, go to IDLE.
- Eligibility and priority:
  - While lock_cnt > 0, only last_served's slot is eligible. lock_cnt decrements once per IDLE cycle with no grant.
  - lock_cnt is cleared when last_served is granted.
  - With lock_cnt == 0 and both slots full, grant the client that is not last_served (round-robin).
  - After reset last_served = 0, so the dcache (client 1) wins the first tie.
- `o_c0_rdata` and `o_c1_rdata` both mirror `i_mem_rdata`. Only the valid signal is steered to the owner.
- `i_mem_valid` while in IDLE is ignored; no client valid is asserted.

## Timing
- Reset (asynchronous, `i_rst_n` low):
  - state = IDLE, slots empty, lock_cnt = 0, last_served = 0.
  - `o_mem_ren`, `o_mem_wen` = 0; `o_mem_addr`, `o_mem_wdata` = 0.
  - `o_cN_ready` = 1 and `o_cN_valid` = 0 once reset is asserted.
- Reset mid-transaction: the in-flight request and the slot contents are discarded. A late `i_mem_valid` after release is ignored.
- Request latency: client request in cycle t, slot full in t+1, grant decided in t+1, memory pulse in t+2 (if `i_mem_ready` is high in t+1).
- Response latency: 0 cycles from `i_mem_valid` to client valid.
- Earliest next grant: the cycle after valid; no memory pulse in the valid cycle itself.
- Line-fill continuity, with the response at cycle v:
  - The cache re-requests in v+1 and its slot fills at v+2.
  - With LOCK_CYCLES = 2 the other client cannot be granted at v+1 or v+2, so all 4 words of a fill are issued back-to-back for that client.
- `i_mem_ready` low in IDLE: no grant and lock_cnt holds.
- Slot capture and grant on the same edge for the same client: grant uses the old contents and capture fills the cleared slot. Legal only because clients keep one request outstanding.

## Test plan
- Reset, then a single read on `c0` at 0x100 (memory returns 0xDEADBEEF two cycles after `o_mem_ren`) -> `o_mem_ren` pulse with addr 0x100 at t+2; `o_c0_valid` = 1 with rdata 0xDEADBEEF; `o_c1_valid` stays 0.
- Simultaneous first requests: c0 read 0x200, c1 write 0x300 data 0x11223344 -> c1 granted first (`o_mem_wen`, wdata 0x11223344), c0 served after c1's valid plus 2 lock cycles.
- c1 4-word fill at 0x400..0x40C with c0 requesting 0x500 during the fill -> memory sees 0x400, 0x404, 0x408, 0x40C contiguously, then 0x500.
- LOCK_CYCLES = 0 with both clients continuously re-requesting -> grants alternate c1, c0, c1, c0.
- `i_mem_ready` held low for 5 cycles with c0 pending -> no `o_mem_*` pulse, `o_c0_ready` = 0; issue occurs the cycle after ready rises.
- Assert `i_rst_n` low while in WAIT, then pulse `i_mem_valid` after release -> no client valid, both ready = 1, memory outputs 0.
